miai_bitserial_alu_seq: RTL and testbench
=========================================

// Module: miai_bitserial_alu_seq
// PURPOSE
//   Sequencer that runs WIDTH-bit operations through one 1-bit ALU slice, LSB first, one bit per clock.
//   Latches the operands on start, shifts them through the slice with a registered carry, assembles
//   the result and flags, then pulses done.
//   Sits between the TinyTapeout top-level pin mapping (ui_in/uio_in -> operands/op) and the 1-bit ALU datapath.
// PARAMETERS
//   WIDTH   8   operand/result width in bits (>=2); also the number of RUN cycles
// PORTS
//   clk        in   1      single clock; all state changes on rising edge
//   rst        in   1      reset, synchronous, active-high
//   start      in   1      request new operation; sampled only in IDLE or DONE
//   op         in   3      opcode (see BEHAVIOUR), latched with start
//   a          in   WIDTH  operand A, latched with start
//   b          in   WIDTH  operand B, latched with start
//   busy       out  1      high while in RUN
//   done       out  1      one-cycle pulse when result/flags become valid
//   result     out  WIDTH  result; held from done until next accepted start
//   carry_out  out  1      final carry (ADD/SUB only, else 0); SUB: 1 = no borrow
//   ovf        out  1      signed overflow (ADD/SUB only, else 0)
//   zero       out  1      result == 0
//   err        out  1      illegal opcode flag, valid with done
// BEHAVIOUR
//   - Reset: state=IDLE; busy, done, result, carry_out, ovf, zero, err all 0; operand shift regs and carry reg cleared.
//   - Opcodes: 000 ADD a+b; 001 SUB a+~b+1; 010 AND; 011 OR; 100 XOR; 101 NOT a; 110/111 illegal.
//   - FSM: IDLE -(start)-> RUN; RUN -(bit counter == WIDTH-1)-> DONE; DONE -(start)-> RUN, else -> IDLE.
//   - start sampled at edge T (IDLE/DONE): operands/op latched; carry reg := 1 for SUB, 0 otherwise;
//     bit counter := 0. busy=1 over cycles T+1..T+WIDTH.
//   - Each RUN cycle: slice gets a_sr[0], b_sr[0] (inverted for SUB), carry reg; sum bit shifted into
//     result shift reg MSB end; a_sr/b_sr shift right; carry reg := slice cout (ADD/SUB only).
//   - done=1 for exactly cycle T+WIDTH+1 (state DONE); result/flags updated on that same edge.
//     Latency start->done = WIDTH+1 cycles.
//   - ovf = carry into MSB XOR carry out of MSB: capture the carry-in on the last RUN cycle.
//   - zero: computed from the final assembled result, not accumulated per bit.
//   - Illegal op: runs the full WIDTH cycles (fixed latency); at done, result=0, err=1, zero=1, carry_out=0, ovf=0.
//   - start while RUN: ignored (no queueing, no restart). start in DONE: accepted, back-to-back, no IDLE gap.
//   - result/flags hold until the edge that accepts the next start, then hold stale values during RUN.
//     err is cleared on accept.
//   - rst asserted mid-RUN: operation aborted, full reset values next cycle, no done pulse.
//   - Bit counter is ceil(log2(WIDTH)) bits; must not wrap before WIDTH-1 is reached.
// STRUCTURE
//   - Package miai_alu_pkg: opcode localparams (OP_ADD..OP_NOT), state encoding (S_IDLE/S_RUN/S_DONE),
//     function is_arith(op).
//   - Sub-module miai_alu1_slice: combinational 1-bit ALU (a, b, cin, op) -> (y, cout). Instantiated once.
//   - Top: FSM, bit counter, a/b/result shift regs, carry reg, flag logic.
// TESTING (WIDTH=8, start pulsed at cycle T)
//   - ADD a=0xFF, b=0x01 -> done at T+9 only; result=0x00, carry_out=1, zero=1, ovf=0, err=0.
//   - ADD 0x7F+0x01 -> 0x80, ovf=1, carry_out=0.
//   - SUB 0x05-0x07 -> 0xFE, carry_out=0, ovf=0.
//   - XOR 0xA5^0xFF -> 0x5A.
//   - NOT 0x0F -> 0xF0; carry_out=0.
//   - start re-pulsed at T+3 with other operands -> ignored, original result at T+9.
//     start held at T+9 -> second done at T+18.
//   - rst at T+4 -> busy=0, all outputs 0 at T+5, no done.
//   - op=111 -> done at T+9, err=1, result=0x00.
//   - op=110 (the other illegal code) -> same response as op=111.

Source files
------------

// File: rtl/miai_alu_pkg.sv
// Shared opcodes, FSM state encoding and decode helpers
// for the bit-serial ALU sequencer.
package miai_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_arith(
    input logic [2:0] op
  );
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic is_legal(
    input logic [2:0] op
  );
    return op <= OP_NOT;
  endfunction

endpackage

// File: rtl/miai_bitserial_alu_seq_if.sv
// Operand/result bundle between the pin mapping
// and the bit-serial ALU sequencer.
interface miai_bitserial_alu_seq_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             ovf;
  logic             zero;
  logic             err;

  modport master (
    output start, op, a, b,
    input  busy, done, result,
    input  carry_out, ovf, zero, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result,
    output carry_out, ovf, zero, err
  );

endinterface

// File: rtl/miai_alu1_slice.sv
// Combinational 1-bit ALU slice; cout is only
// meaningful for ADD/SUB and is 0 otherwise.
module miai_alu1_slice
  import miai_alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       cin_i,
  input  logic [2:0] op_i,
  output logic       y_o,
  output logic       cout_o
);

  always_comb begin
    y_o    = 1'b0;
    cout_o = 1'b0;
    unique case (1'b1)
      is_arith(op_i): begin
        y_o    = a_i ^ b_i ^ cin_i;
        cout_o = (a_i & b_i) | (a_i & cin_i)
               | (b_i & cin_i);
      end
      (op_i == OP_AND): y_o = a_i & b_i;
      (op_i == OP_OR):  y_o = a_i | b_i;
      (op_i == OP_XOR): y_o = a_i ^ b_i;
      (op_i == OP_NOT): y_o = ~a_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/miai_bitserial_alu_seq.sv
// Bit-serial ALU sequencer: shifts WIDTH-bit operands
// LSB first through one slice, then pulses done.
module miai_bitserial_alu_seq
  import miai_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                     clk,
  input logic                     rst,
  miai_bitserial_alu_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic             carry_q, carry_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic             s_b;
  logic             s_y;
  logic             s_cout;
  logic             last;
  logic [WIDTH-1:0] res_final;

  assign s_b = b_sr_q[0] ^ (op_q == OP_SUB);
  assign last = (cnt_q == CW'(WIDTH - 1));
  assign res_final = {s_y, res_sr_q[WIDTH-1:1]};

  miai_alu1_slice u_slice (
    .a_i    (a_sr_q[0]),
    .b_i    (s_b),
    .cin_i  (carry_q),
    .op_i   (op_q),
    .y_o    (s_y),
    .cout_o (s_cout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    op_d     = op_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    err_d    = err_q;

    unique case (state_q)
      S_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = res_final;
        cnt_d    = cnt_q + CW'(1);
        if (is_arith(op_q)) carry_d = s_cout;
        if (last) begin
          state_d = S_DONE;
          // ovf compares the carry into and out of the MSB
          if (is_legal(op_q)) begin
            result_d = res_final;
            zero_d   = (res_final == '0);
            err_d    = 1'b0;
          end else begin
            result_d = '0;
            zero_d   = 1'b1;
            err_d    = 1'b1;
          end
          cout_d = is_arith(op_q) & s_cout;
          ovf_d  = is_arith(op_q)
                 & (carry_q ^ s_cout);
        end
      end
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          state_d = S_RUN;
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          op_d    = bus.op;
          carry_d = (bus.op == OP_SUB);
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      op_q     <= OP_ADD;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_miai_bitserial_alu_seq.sv
// Scoreboard bench for the bit-serial ALU sequencer
// at WIDTH=8.
module tb_miai_bitserial_alu_seq;

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       v;
    logic       z;
    logic       e;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];
  logic [7:0] prev_r;

  miai_bitserial_alu_seq_if #(.WIDTH(8)) bus ();

  miai_bitserial_alu_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    exp_t x;
    logic [8:0] s;
    x = '0;
    s = '0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        x.r = s[7:0];
        x.c = s[8];
        x.v = (a[7] == b[7]) && (x.r[7] != a[7]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 9'd1;
        x.r = s[7:0];
        x.c = s[8];
        x.v = (a[7] != b[7]) && (x.r[7] != a[7]);
      end
      3'd2: x.r = a & b;
      3'd3: x.r = a | b;
      3'd4: x.r = a ^ b;
      3'd5: x.r = ~a;
      default: x.e = 1'b1;
    endcase
    x.z = (x.r == 8'h00);
    return x;
  endfunction

  task automatic drive_start(
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    sb.push_back(model(op, a, b));
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
  endtask

  // counts edges from the accepting edge; n is the cycle index T+n
  task automatic wait_done(input int repulse_at);
    int n;
    n = 0;
    while (n < 30) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
          failures++;
          $display("FAIL accept_busy busy=%b done=%b want 1/0",
                   bus.busy, bus.done);
        end
        checks++;
        if (bus.result !== prev_r || bus.err !== 1'b0) begin
          failures++;
          $display("FAIL stale_hold result=%h err=%b want %h/0",
                   bus.result, bus.err, prev_r);
        end
      end
      if (n == repulse_at) begin
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.a     = 8'h11;
        bus.b     = 8'h22;
      end
      if (n == repulse_at + 1) bus.start = 1'b0;
      if (bus.done === 1'b1) break;
    end
    checks++;
    if (n != 9) begin
      failures++;
      $display("FAIL latency cycles=%0d want 9", n);
    end
    if (bus.done === 1'b1) check_pop();
  endtask

  task automatic check_pop();
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty got done with nothing queued");
      return;
    end
    x = sb.pop_front();
    prev_r = x.r;
    if (bus.result !== x.r || bus.carry_out !== x.c ||
        bus.ovf !== x.v || bus.zero !== x.z ||
        bus.err !== x.e || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL result got r=%h c=%b v=%b z=%b e=%b want r=%h c=%b v=%b z=%b e=%b",
               bus.result, bus.carry_out, bus.ovf,
               bus.zero, bus.err, x.r, x.c, x.v, x.z, x.e);
    end
  endtask

  task automatic run_op(
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    drive_start(op, a, b);
    wait_done(-10);
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.result !== prev_r) begin
      failures++;
      $display("FAIL done_pulse done=%b result=%h want 0/%h",
               bus.done, bus.result, prev_r);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    prev_r = 8'h00;
    checks++;
    if ({bus.busy, bus.done, bus.result, bus.carry_out,
         bus.ovf, bus.zero, bus.err} !== 14'd0) begin
      failures++;
      $display("FAIL reset busy=%b done=%b r=%h c=%b v=%b z=%b e=%b want all 0",
               bus.busy, bus.done, bus.result, bus.carry_out,
               bus.ovf, bus.zero, bus.err);
    end
  endtask

  task automatic test_directed();
    run_op(3'd0, 8'hFF, 8'h01);
    run_op(3'd0, 8'h7F, 8'h01);
    run_op(3'd1, 8'h05, 8'h07);
    run_op(3'd1, 8'h80, 8'h01);
    run_op(3'd1, 8'h33, 8'h00);
    run_op(3'd4, 8'hA5, 8'hFF);
    run_op(3'd5, 8'h0F, 8'h00);
    run_op(3'd2, 8'hC3, 8'h5A);
    run_op(3'd3, 8'h00, 8'h00);
  endtask

  task automatic test_illegal();
    run_op(3'd7, 8'hFF, 8'h01);
    run_op(3'd6, 8'h12, 8'h34);
  endtask

  task automatic test_ignore_start();
    drive_start(3'd0, 8'h40, 8'h05);
    wait_done(3);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.result !== prev_r || bus.done !== 1'b0 ||
        bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold result=%h done=%b busy=%b want %h/0/0",
               bus.result, bus.done, bus.busy, prev_r);
    end
  endtask

  task automatic test_back_to_back();
    drive_start(3'd1, 8'h10, 8'h20);
    wait_done(-10);
    drive_start(3'd0, 8'h81, 8'h81);
    wait_done(-10);
    @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset();
    bit seen;
    seen = 1'b0;
    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    repeat (4) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.result, bus.carry_out,
         bus.ovf, bus.zero, bus.err} !== 14'd0) begin
      failures++;
      $display("FAIL mid_reset busy=%b done=%b r=%h c=%b v=%b z=%b e=%b want all 0",
               bus.busy, bus.done, bus.result, bus.carry_out,
               bus.ovf, bus.zero, bus.err);
    end
    prev_r = 8'h00;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL abort_no_done saw done/busy=1 want 0");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_op(3'($urandom_range(0, 7)),
             8'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    prev_r    = 8'h00;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    @(negedge clk);
    test_reset();
    test_directed();
    test_illegal();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left entries=%0d want 0",
               sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
